// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter that shares one pipelined adder between NREQ requesters.
// Optional ARB_STATS_EN adds issue_cnt / lane_hits statistics ports.
module adder_share_arbiter #(
    parameter int unsigned DW         = 8,
    parameter int unsigned NREQ       = 4,
    parameter int unsigned ADDER_REGS = 4,
    parameter int unsigned TW         = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*DW-1:0]   req_a,
    input  logic [NREQ*DW-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [DW-1:0]        rsp_sum,
    output logic                 busy
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]          issue_cnt,
    output logic [NREQ*16-1:0]   lane_hits
`endif
);

    localparam int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned LAST = ADDER_REGS - 1;

    logic [PW-1:0]          rr_ptr;
    logic [PW-1:0]          gnt_idx;
    logic                   gnt;
    logic [31:0]            scan;
    logic [DW-1:0]          op_a;
    logic [DW-1:0]          op_b;
    logic [ADDER_REGS-1:0]  vld_pipe;
    logic [TW-1:0]          tag_pipe [ADDER_REGS];
    logic [DW-1:0]          sum_pipe [ADDER_REGS];

    // Work-conserving search starting at rr_ptr; reset and en both block grants.
    always_comb begin
        gnt     = 1'b0;
        gnt_idx = '0;
        scan    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan = 32'(rr_ptr) + 32'(k);
            if (scan >= 32'(NREQ)) begin
                scan = scan - 32'(NREQ);
            end
            if (!gnt && en && rst_n && req_valid[PW'(scan)]) begin
                gnt     = 1'b1;
                gnt_idx = PW'(scan);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        op_a      = '0;
        op_b      = '0;
        if (gnt) begin
            req_ready[gnt_idx] = 1'b1;
            op_a               = req_a[gnt_idx*DW +: DW];
            op_b               = req_b[gnt_idx*DW +: DW];
        end
    end

    // Valid/tag shift pipe tracks the adder stages so each sum returns to its issuer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            vld_pipe <= '0;
            for (int unsigned k = 0; k < ADDER_REGS; k++) begin
                tag_pipe[k] <= '0;
            end
        end else begin
            vld_pipe[0] <= gnt;
            tag_pipe[0] <= gnt ? TW'(gnt_idx) : '0;
            for (int unsigned k = 1; k < ADDER_REGS; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                tag_pipe[k] <= tag_pipe[k-1];
            end
            if (gnt) begin
                rr_ptr <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    // Pipelined adder datapath; data registers carry no reset.
    always_ff @(posedge clk) begin
        sum_pipe[0] <= op_a + op_b;
        for (int unsigned k = 1; k < ADDER_REGS; k++) begin
            sum_pipe[k] <= sum_pipe[k-1];
        end
    end

    always_comb begin
        rsp_valid = '0;
        rsp_sum   = '0;
        if (vld_pipe[LAST]) begin
            rsp_valid[tag_pipe[LAST]] = 1'b1;
            rsp_sum                   = sum_pipe[LAST];
        end
    end

    assign busy = |vld_pipe;

`ifdef ARB_STATS_EN
    // Handshake counters: total wraps, per-lane saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt <= '0;
            lane_hits <= '0;
        end else if (gnt) begin
            issue_cnt <= issue_cnt + 32'd1;
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (gnt_idx == PW'(i) && lane_hits[i*16 +: 16] != 16'hFFFF) begin
                    lane_hits[i*16 +: 16] <= lane_hits[i*16 +: 16] + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Scoreboard bench for adder_share_arbiter: grants checked against a rotation model,
// responses popped from an expected queue with sum and latency checks.
module tb_adder_share_arbiter;

    localparam int unsigned DW         = 8;
    localparam int unsigned NREQ       = 4;
    localparam int unsigned ADDER_REGS = 4;
    localparam int unsigned TW         = 2;

    logic                 clk;
    logic                 rst_n;
    logic                 en;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*DW-1:0]   req_a;
    logic [NREQ*DW-1:0]   req_b;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      rsp_valid;
    logic [DW-1:0]        rsp_sum;
    logic                 busy;
`ifdef ARB_STATS_EN
    logic [31:0]          issue_cnt;
    logic [NREQ*16-1:0]   lane_hits;
`endif

    adder_share_arbiter #(
        .DW(DW), .NREQ(NREQ), .ADDER_REGS(ADDER_REGS), .TW(TW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_sum   (rsp_sum),
        .busy      (busy)
`ifdef ARB_STATS_EN
        ,
        .issue_cnt (issue_cnt),
        .lane_hits (lane_hits)
`endif
    );

    typedef struct {
        int tag;
        int sum;
        int due;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;
    int   cyc    = 0;
    int   m_ptr  = 0;
    int   m_issue = 0;
    int   m_hits [NREQ];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        checks++;
        if (ok) passed++;
        else $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    endtask

    // Monitor: samples on the falling edge, mid-cycle.
    always @(negedge clk) begin
        int   g;
        int   a;
        int   b;
        int   exp_ready;
        exp_t e;
        if (!rst_n) begin
            chk(req_ready == 0 && rsp_valid == 0 && rsp_sum == 0 && busy == 0,
                "reset_outputs", {req_ready, rsp_valid, rsp_sum, busy}, 0);
`ifdef ARB_STATS_EN
            chk(issue_cnt == 0, "reset_issue_cnt", issue_cnt, 0);
`endif
            exp_q.delete();
            m_ptr   = 0;
            m_issue = 0;
            foreach (m_hits[i]) m_hits[i] = 0;
        end else begin
            cyc++;
            chk(busy == (exp_q.size() != 0), "busy", busy, exp_q.size() != 0);
`ifdef ARB_STATS_EN
            chk(issue_cnt == 32'(m_issue), "issue_cnt", issue_cnt, m_issue);
            for (int i = 0; i < NREQ; i++)
                chk(lane_hits[i*16 +: 16] == 16'(m_hits[i]), "lane_hits", lane_hits[i*16 +: 16], m_hits[i]);
`endif
            if (rsp_valid != 0) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "rsp_unexpected", rsp_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk(rsp_valid == NREQ'(1 << e.tag), "rsp_valid", rsp_valid, 1 << e.tag);
                    chk(int'(rsp_sum) == e.sum, "rsp_sum", rsp_sum, e.sum);
                    chk(cyc == e.due, "rsp_latency", cyc, e.due);
                end
            end else begin
                chk(rsp_sum == 0, "rsp_sum_idle", rsp_sum, 0);
                if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
                    chk(1'b0, "rsp_missing", 0, exp_q[0].due);
                    void'(exp_q.pop_front());
                end
            end
            // Reference grant: first valid requester scanning from the pointer.
            g = -1;
            if (en) begin
                for (int k = 0; k < NREQ; k++) begin
                    int i;
                    i = (m_ptr + k) % NREQ;
                    if (g < 0 && req_valid[i]) g = i;
                end
            end
            exp_ready = (g >= 0) ? (1 << g) : 0;
            chk(req_ready == NREQ'(exp_ready), "grant", req_ready, exp_ready);
            if (g >= 0) begin
                a = int'(req_a[g*DW +: DW]);
                b = int'(req_b[g*DW +: DW]);
                exp_q.push_back('{tag: g, sum: (a + b) % (1 << DW), due: cyc + ADDER_REGS});
                m_ptr = (g + 1) % NREQ;
                m_issue++;
                if (m_hits[g] < 65535) m_hits[g]++;
            end
        end
    end

    task automatic drive(input logic [NREQ-1:0] v, input logic e);
        @(posedge clk);
        #1;
        req_valid = v;
        en        = e;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*DW +: DW] = DW'($urandom);
            req_b[i*DW +: DW] = DW'($urandom);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive('0, 1'b1);
    endtask

    initial begin
        rst_n     = 1'b1;
        en        = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single op: 3 + 5 on requester 0.
        drive(4'b0001, 1'b1);
        req_a[0 +: DW] = 8'd3;
        req_b[0 +: DW] = 8'd5;
        idle(6);

        // All requesters valid: rotating grants.
        repeat (8) drive(4'b1111, 1'b1);
        idle(6);

        // Wrap: 200 + 100 on requester 2.
        drive(4'b0100, 1'b1);
        req_a[2*DW +: DW] = 8'd200;
        req_b[2*DW +: DW] = 8'd100;
        idle(6);

        // en drops mid-stream: in-flight ops still drain.
        repeat (3) drive(4'b1111, 1'b1);
        repeat (4) drive(4'b1111, 1'b0);
        idle(6);

        // Reset with ops in flight: results dropped, pointer back to 0.
        repeat (2) drive(4'b1111, 1'b1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        req_valid = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(8);
        repeat (2) drive(4'b1111, 1'b1);
        idle(6);

        // Single requester back-to-back.
        repeat (5) drive(4'b0100, 1'b1);
        idle(6);

        // Randomised traffic.
        repeat (400) drive(NREQ'($urandom), ($urandom % 8) != 0);
        idle(10);

        chk(exp_q.size() == 0, "drain_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
